// File: rtl/mdu_pkg.sv
// Shared definitions for the HiLo multiply/divide sequencer: operation
// encodings, controller state encoding and small op-decode helpers.
package mdu_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ITER_COUNT = WIDTH_DEF;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_LO   = 2'b01;
    localparam logic [1:0] WR_HI   = 2'b10;
    localparam logic [1:0] WR_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Operations that need the iterative datapath.
    function automatic logic op_is_muldiv(input logic [2:0] op);
        op_is_muldiv = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    // Operations that write one half directly from srcA.
    function automatic logic op_is_move(input logic [2:0] op);
        op_is_move = (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    // Operations that work on magnitudes and need a sign fix-up.
    function automatic logic op_is_signed(input logic [2:0] op);
        op_is_signed = (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Divide operations (restoring division mode of the iteration step).
    function automatic logic op_is_div(input logic [2:0] op);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// Execute-stage request / HiLo write-back bundle of the multiply/divide unit.
// The master side issues requests and consumes the HiLo write; the slave side
// is the sequencer.
interface hilo_mdu_ctrl_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] dinHi;
    logic [WIDTH-1:0] dinLo;
    logic [1:0]       hlWrite;
    logic             divByZero;

    modport master (
        output start, op, srcA, srcB, cancel,
        input  busy, dinHi, dinLo, hlWrite, divByZero
    );

    modport slave (
        input  start, op, srcA, srcB, cancel,
        output busy, dinHi, dinLo, hlWrite, divByZero
    );

endinterface

// File: rtl/mdu_iter.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: shift-add, {acc_hi, acc_lo} holds {partial product, multiplier}
// and shifts right by one each step. Divide: restoring, acc_hi holds the
// partial remainder and acc_lo the dividend bits still to be brought down;
// the new quotient bit is returned separately and the caller shifts it in.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    input  logic             div_mode,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo,
    output logic             q_bit
);

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_fits_s;

    // Candidate results for both modes.
    always_comb begin
        mul_sum_s = {1'b0, acc_hi};
        if (acc_lo[0]) begin
            mul_sum_s = {1'b0, acc_hi} + {1'b0, operand};
        end else begin
            mul_sum_s = {1'b0, acc_hi};
        end
        div_shift_s = {acc_hi, acc_lo[WIDTH-1]};
        div_fits_s  = (div_shift_s >= {1'b0, operand});
        // Only used when the divisor fits, so the result is below 2^WIDTH.
        div_diff_s  = div_shift_s[WIDTH-1:0] - operand;
    end

    // Select the step result for the active mode.
    always_comb begin
        next_hi = {WIDTH{1'b0}};
        next_lo = {WIDTH{1'b0}};
        q_bit   = 1'b0;
        if (div_mode) begin
            next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            if (div_fits_s) begin
                next_hi = div_diff_s;
                q_bit   = 1'b1;
            end else begin
                next_hi = div_shift_s[WIDTH-1:0];
                q_bit   = 1'b0;
            end
        end else begin
            next_hi = mul_sum_s[WIDTH:1];
            next_lo = {mul_sum_s[0], acc_lo[WIDTH-1:1]};
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Multiply/divide sequencer owning the write side of the HiLo pair.
// Latches a request in IDLE, runs WIDTH iterations in CALC on operand
// magnitudes, applies the sign fix-up on the last step and presents a
// one-cycle HiLo write in DONE. cancel aborts CALC/DONE without writing.
module hilo_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    hilo_mdu_ctrl_if.slave   bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] din_hi_r;
    logic [WIDTH-1:0] din_lo_r;
    logic             dbz_r;
    logic [1:0]       wr_mask_r;

    logic             accept_s;
    logic             start_calc_s;
    logic             start_move_s;
    logic [WIDTH-1:0] init_lo_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH-1:0] iter_operand_s;
    logic [WIDTH-1:0] iter_hi_s;
    logic [WIDTH-1:0] iter_lo_s;
    logic             iter_q_s;
    logic [WIDTH-1:0] quot_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;
    logic             res_dbz_s;

    // Two's-complement magnitude when the value is treated as signed.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                                input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            mag_of = -v;
        end else begin
            mag_of = v;
        end
    endfunction

    // Request decode: cancel blocks an accept in the same cycle.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && bus.start && !bus.cancel;
        start_calc_s = accept_s && op_is_muldiv(bus.op);
        start_move_s = accept_s && op_is_move(bus.op);
        if (op_is_div(bus.op)) begin
            init_lo_s = mag_of(bus.srcA, op_is_signed(bus.op));
        end else begin
            init_lo_s = mag_of(bus.srcB, op_is_signed(bus.op));
        end
    end

    // Operand magnitudes and iteration-step operand from the latched request.
    always_comb begin
        mag_a_s = mag_of(a_r, op_is_signed(op_r));
        mag_b_s = mag_of(b_r, op_is_signed(op_r));
        if (op_is_div(op_r)) begin
            iter_operand_s = mag_b_s;
        end else begin
            iter_operand_s = mag_a_s;
        end
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .acc_hi   (acc_hi_r),
        .acc_lo   (acc_lo_r),
        .operand  (iter_operand_s),
        .div_mode (op_is_div(op_r)),
        .next_hi  (iter_hi_s),
        .next_lo  (iter_lo_s),
        .q_bit    (iter_q_s)
    );

    // Final-step result with sign fix-up and the divide-by-zero override.
    always_comb begin
        quot_s    = iter_lo_s | {{(WIDTH-1){1'b0}}, iter_q_s};
        prod_s    = {iter_hi_s, iter_lo_s};
        res_hi_s  = {WIDTH{1'b0}};
        res_lo_s  = {WIDTH{1'b0}};
        res_dbz_s = 1'b0;
        if (op_is_div(op_r)) begin
            if (b_r == {WIDTH{1'b0}}) begin
                res_hi_s  = a_r;
                res_lo_s  = {WIDTH{1'b1}};
                res_dbz_s = 1'b1;
            end else begin
                if (op_is_signed(op_r) && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) begin
                    res_lo_s = -quot_s;
                end else begin
                    res_lo_s = quot_s;
                end
                if (op_is_signed(op_r) && a_r[WIDTH-1]) begin
                    res_hi_s = -iter_hi_s;
                end else begin
                    res_hi_s = iter_hi_s;
                end
                res_dbz_s = 1'b0;
            end
        end else begin
            if (op_is_signed(op_r) && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) begin
                prod_s = -prod_s;
            end else begin
                prod_s = {iter_hi_s, iter_lo_s};
            end
            res_hi_s  = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s  = prod_s[WIDTH-1:0];
            res_dbz_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_calc_s) begin
                    state_next_s = ST_CALC;
                end else if (start_move_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.cancel) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Outputs: state decodes; cancel squashes the write in the same cycle.
    always_comb begin
        bus.busy      = (state_r != ST_IDLE);
        bus.dinHi     = din_hi_r;
        bus.dinLo     = din_lo_r;
        bus.divByZero = dbz_r;
        if ((state_r == ST_DONE) && !bus.cancel) begin
            bus.hlWrite = wr_mask_r;
        end else begin
            bus.hlWrite = WR_NONE;
        end
    end

    // Operand latches, iteration datapath and HiLo write-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= OP_NOP;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            din_hi_r  <= {WIDTH{1'b0}};
            din_lo_r  <= {WIDTH{1'b0}};
            dbz_r     <= 1'b0;
            wr_mask_r <= WR_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_calc_s) begin
                        op_r     <= bus.op;
                        a_r      <= bus.srcA;
                        b_r      <= bus.srcB;
                        cnt_r    <= {CNT_W{1'b0}};
                        acc_hi_r <= {WIDTH{1'b0}};
                        acc_lo_r <= init_lo_s;
                    end else if (start_move_s) begin
                        op_r  <= bus.op;
                        a_r   <= bus.srcA;
                        dbz_r <= 1'b0;
                        if (bus.op == OP_MTHI) begin
                            din_hi_r  <= bus.srcA;
                            din_lo_r  <= {WIDTH{1'b0}};
                            wr_mask_r <= WR_HI;
                        end else begin
                            din_hi_r  <= {WIDTH{1'b0}};
                            din_lo_r  <= bus.srcA;
                            wr_mask_r <= WR_LO;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_CALC: begin
                    if (bus.cancel) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        acc_hi_r <= iter_hi_s;
                        acc_lo_r <= iter_lo_s | {{(WIDTH-1){1'b0}}, iter_q_s};
                        if (cnt_r == CNT_LAST) begin
                            cnt_r     <= {CNT_W{1'b0}};
                            din_hi_r  <= res_hi_s;
                            din_lo_r  <= res_lo_s;
                            dbz_r     <= res_dbz_s;
                            wr_mask_r <= WR_BOTH;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    din_hi_r  <= {WIDTH{1'b0}};
                    din_lo_r  <= {WIDTH{1'b0}};
                    dbz_r     <= 1'b0;
                    wr_mask_r <= WR_NONE;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: the stimulus side pushes the expected
// HiLo write (data, mask, divide-by-zero flag and the cycle it must appear
// in) computed with plain 64-bit arithmetic; a monitor pops and compares
// whenever hlWrite is nonzero.
module tb_hilo_mdu_ctrl;

    localparam logic [2:0] T_NOP = 3'd0, T_MULT = 3'd1, T_MULTU = 3'd2, T_DIV = 3'd3;
    localparam logic [2:0] T_DIVU = 3'd4, T_MTHI = 3'd5, T_MTLO = 3'd6, T_RSVD = 3'd7;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  mask;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    hilo_mdu_ctrl_if #(.WIDTH(32)) bus_if ();

    hilo_mdu_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: MIPS HiLo semantics from 64-bit integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int now);
        exp_t e;
        longint sa, sb, q, r;
        logic [63:0] p;
        e.hi = 32'd0; e.lo = 32'd0; e.dbz = 1'b0; e.mask = 2'b11;
        e.cyc = now + 33;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            T_MULT:  begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            T_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            T_DIV, T_DIVU: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (op == T_DIV) begin
                    q = sa / sb; r = sa % sb;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            T_MTHI:  begin e.hi = a; e.mask = 2'b10; e.cyc = now + 1; end
            T_MTLO:  begin e.lo = a; e.mask = 2'b01; e.cyc = now + 1; end
            default: begin e.mask = 2'b00; end
        endcase
        return e;
    endfunction

    function automatic logic writes(input logic [2:0] op);
        return (op != T_NOP) && (op != T_RSVD);
    endfunction

    // Monitor: every nonzero hlWrite must match the oldest expectation.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus_if.hlWrite != 2'b00) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got hlWrite=%b hi=%h lo=%h at cycle %0d, expected no write",
                             bus_if.hlWrite, bus_if.dinHi, bus_if.dinLo, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (bus_if.hlWrite !== e.mask || bus_if.dinHi !== e.hi ||
                        bus_if.dinLo !== e.lo || bus_if.divByZero !== e.dbz || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL hilo_write: got mask=%b hi=%h lo=%h dbz=%b cyc=%0d, expected mask=%b hi=%h lo=%h dbz=%b cyc=%0d",
                                 bus_if.hlWrite, bus_if.dinHi, bus_if.dinLo, bus_if.divByZero, cyc,
                                 e.mask, e.hi, e.lo, e.dbz, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Present one request for one cycle; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic expect_write);
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.srcA  = a;
        bus_if.srcB  = b;
        if (expect_write) sb_q.push_back(model(op, a, b, cyc));
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    // Count cycles busy stays high (starting just after the accept edge).
    task automatic wait_idle(output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        while (bus_if.busy && n < 100) begin
            busy_cycles++;
            n++;
            @(posedge clk); #1;
        end
        if (bus_if.busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, expected 0", bus_if.busy, n);
        end
    endtask

    initial begin
        int bc;
        int tgt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.op = 3'd0; bus_if.cancel = 1'b0;
        bus_if.srcA = 32'd0; bus_if.srcB = 32'd0;
        fork monitor_loop(); join_none
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy",    {63'd0, bus_if.busy}, 64'd0);
        check_val("reset_hlwrite", {62'd0, bus_if.hlWrite}, 64'd0);
        check_val("reset_din",     {bus_if.dinHi, bus_if.dinLo}, 64'd0);
        check_val("reset_dbz",     {63'd0, bus_if.divByZero}, 64'd0);
        rst = 1'b0;

        // Directed corner cases.
        issue(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_idle(bc);
        check_val("multu_busy_cycles", 64'(bc), 64'd33);
        issue(T_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);          wait_idle(bc);
        issue(T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);           wait_idle(bc);
        issue(T_DIVU, 32'h1234_5678, 32'd0, 1'b1);          wait_idle(bc);
        issue(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_idle(bc);
        issue(T_DIV, 32'h0000_0005, 32'd0, 1'b1);           wait_idle(bc);

        // Moves: one-cycle busy, then back-to-back MTHI/MTLO.
        issue(T_MTHI, 32'hABCD_0123, 32'd0, 1'b1);
        wait_idle(bc);
        check_val("mthi_busy_cycles", 64'(bc), 64'd1);
        issue(T_MTHI, 32'h1111_1111, 32'd0, 1'b1);
        issue(T_MTLO, 32'h4444_4444, 32'd0, 1'b1);
        wait_idle(bc);

        // start during a DIV is ignored.
        issue(T_DIV, 32'd100, 32'd7, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        bus_if.start = 1'b1; bus_if.op = T_MTHI; bus_if.srcA = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_idle(bc);

        // cancel at iteration 10 of a DIVU, then a clean MULTU.
        issue(T_DIVU, 32'h8765_4321, 32'd13, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        bus_if.cancel = 1'b1;
        @(posedge clk); #1;
        bus_if.cancel = 1'b0;
        check_val("busy_after_cancel", {63'd0, bus_if.busy}, 64'd0);
        issue(T_MULTU, 32'd2, 32'd3, 1'b1);
        wait_idle(bc);

        // Reset at iteration 20 of a MULT.
        issue(T_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid_busy",    {63'd0, bus_if.busy}, 64'd0);
        check_val("rst_mid_hlwrite", {62'd0, bus_if.hlWrite}, 64'd0);
        check_val("rst_mid_din",     {bus_if.dinHi, bus_if.dinLo}, 64'd0);
        check_val("rst_mid_dbz",     {63'd0, bus_if.divByZero}, 64'd0);
        rst = 1'b0;

        // cancel during DONE suppresses the write.
        issue(T_MULTU, 32'd5, 32'd6, 1'b0);
        tgt = cyc + 32;
        while (cyc < tgt) begin @(posedge clk); #1; end
        check_val("done_busy_before_cancel", {63'd0, bus_if.busy}, 64'd1);
        bus_if.cancel = 1'b1;
        #1;
        check_val("done_cancel_hlwrite", {62'd0, bus_if.hlWrite}, 64'd0);
        @(posedge clk); #1;
        bus_if.cancel = 1'b0;
        check_val("done_cancel_busy", {63'd0, bus_if.busy}, 64'd0);

        // Randomized requests.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 20));
                default: ra = ra;
            endcase
            issue(rop, ra, rb, writes(rop));
            if (writes(rop)) begin
                wait_idle(bc);
            end else begin
                check_val("nop_stays_idle", {63'd0, bus_if.busy}, 64'd0);
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
